// File: rtl/fdiv.sv
// +------------------------------------------------------------------+
// | fdiv : multi-cycle binary32 divider (q = a / b), restoring radix-2 |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module fdiv (
   input  logic        clk,
   input  logic        rst,
   input  logic        dispatch,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  op,
   output logic [31:0] q,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIV   = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [31:0] C_DEFAULT_NAN = 32'hFFC00000;
   localparam logic [4:0]  C_LAST_ITER   = 5'd25;

   state_t             r_state;
   state_t             w_next;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [1:0]         r_op;
   logic               r_sign;
   logic [25:0]        r_rem;
   logic [23:0]        r_mb;
   logic [25:0]        r_quo;
   logic signed [9:0]  r_exp;
   logic [4:0]         r_cnt;
   logic               r_rphase;
   logic [31:0]        r_q;

   // one restoring step
   logic               w_ge;
   logic [25:0]        w_diff;
   assign w_ge   = (r_rem >= {2'b00, r_mb});
   assign w_diff = r_rem - (w_ge ? {2'b00, r_mb} : 26'd0);

   // rounding of the normalised quotient
   logic               w_guard;
   logic               w_sticky;
   logic               w_inc;
   logic [24:0]        w_sum;
   logic signed [9:0]  w_exp_r;
   logic [22:0]        w_frac;
   assign w_guard  = r_quo[1];
   assign w_sticky = r_quo[0] | (|r_rem);
   assign w_inc    = w_guard & (w_sticky | r_quo[2]);
   assign w_sum    = {1'b0, r_quo[25:2]} + {24'd0, w_inc};
   assign w_exp_r  = r_exp + $signed({9'd0, w_sum[24]});
   assign w_frac   = w_sum[24] ? 23'd0 : w_sum[22:0];

   // operand classes (denormals read as zero)
   logic w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   assign w_a_max  = &r_a[30:23];
   assign w_b_max  = &r_b[30:23];
   assign w_a_nan  = w_a_max & (|r_a[22:0]);
   assign w_b_nan  = w_b_max & (|r_b[22:0]);
   assign w_a_inf  = w_a_max & ~(|r_a[22:0]);
   assign w_b_inf  = w_b_max & ~(|r_b[22:0]);
   assign w_a_zero = ~(|r_a[30:23]);
   assign w_b_zero = ~(|r_b[30:23]);

   logic [31:0] w_result;
   always_comb begin
      w_result = {r_sign, w_exp_r[7:0], w_frac};
      if (r_op != 2'd0)
         w_result = C_DEFAULT_NAN;
      else if (w_a_nan)
         w_result = r_a | 32'h0040_0000;
      else if (w_b_nan)
         w_result = r_b | 32'h0040_0000;
      else if ((w_a_inf & w_b_inf) | (w_a_zero & w_b_zero))
         w_result = C_DEFAULT_NAN;
      else if (w_a_inf | w_b_zero)
         w_result = {r_sign, 8'hFF, 23'd0};
      else if (w_a_zero | w_b_inf)
         w_result = {r_sign, 31'd0};
      else if (w_exp_r >= 10'sd255)
         w_result = {r_sign, 8'hFF, 23'd0};
      else if (w_exp_r <= 10'sd0)
         w_result = {r_sign, 31'd0};
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (dispatch) w_next = S_DIV;
         S_DIV:   if (r_cnt == C_LAST_ITER) w_next = S_ROUND;
         S_ROUND: if (r_rphase) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_q      <= 32'd0;
         r_cnt    <= 5'd0;
         r_rphase <= 1'b0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_op     <= 2'd0;
         r_sign   <= 1'b0;
         r_rem    <= 26'd0;
         r_mb     <= 24'd0;
         r_quo    <= 26'd0;
         r_exp    <= 10'sd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (dispatch) begin
               r_a    <= a;
               r_b    <= b;
               r_op   <= op;
               r_sign <= a[31] ^ b[31];
               // special operands get a meaningless quotient; ROUND overrides it
               r_rem  <= {3'b001, a[22:0]};
               r_mb   <= {1'b1, b[22:0]};
               r_quo  <= 26'd0;
               r_exp  <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
               r_cnt  <= 5'd0;
            end
            S_DIV: begin
               r_quo <= {r_quo[24:0], w_ge};
               r_rem <= {w_diff[24:0], 1'b0};
               r_cnt <= r_cnt + 5'd1;
            end
            S_ROUND: begin
               if (!r_rphase) begin
                  // ratio in (0.5,1): bring the leading one to bit 25
                  if (!r_quo[25]) begin
                     r_quo <= {r_quo[24:0], 1'b0};
                     r_exp <= r_exp - 10'sd1;
                  end
                  r_rphase <= 1'b1;
               end else begin
                  r_q      <= w_result;
                  r_rphase <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign q    = r_q;
   assign done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fdiv.sv
// +------------------------------------------------------------------+
// | tb_fdiv : directed self-checking bench for fdiv                  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fdiv;

   logic        clk;
   logic        rst;
   logic        dispatch;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  op;
   logic [31:0] q;
   logic        done;

   int checks = 0;
   int errors = 0;

   fdiv dut (
      .clk      (clk),
      .rst      (rst),
      .dispatch (dispatch),
      .a        (a),
      .b        (b),
      .op       (op),
      .q        (q),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] top,
                      input logic [31:0] exp_q, input string tag, input bit poke);
      int n;
      bit seen;
      @(negedge clk);
      a = ta; b = tb_v; op = top; dispatch = 1'b1;
      @(posedge clk); #1;
      dispatch = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 60) begin
         if (poke && (n == 5 || n == 20)) begin
            dispatch = 1'b1; a = 32'h0; b = 32'h3F800000;
         end else begin
            dispatch = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      dispatch = 1'b0;
      check({31'd0, seen}, 32'd1, {tag, " done_seen"});
      check(n, 28, {tag, " latency"});
      check(q, exp_q, {tag, " q"});
      @(posedge clk); #1;
      check({31'd0, done}, 32'd0, {tag, " single_pulse"});
      check(q, exp_q, {tag, " q_held"});
   endtask

   task automatic quiet(input int cycles, input string tag);
      bit any;
      any = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) any = 1'b1;
      end
      check({31'd0, any}, 32'd0, {tag, " no_done"});
   endtask

   initial begin
      rst = 1'b1; dispatch = 1'b0; a = 32'd0; b = 32'd0; op = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check({31'd0, done}, 32'd0, "reset done");
      check(q, 32'd0, "reset q");
      @(negedge clk);
      rst = 1'b0;

      run(32'h3F800000, 32'h3F800000, 2'd0, 32'h3F800000, "one_div_one", 1'b0);
      run(32'h3F800000, 32'h3F000000, 2'd0, 32'h40000000, "one_div_half", 1'b0);
      run(32'h3F800000, 32'h3FFFFFFF, 2'd0, 32'h3F000001, "norm_roundup", 1'b0);
      run(32'h40490FDB, 32'h402DF854, 2'd0, 32'h3F93EEE0, "pi_div_e", 1'b0);
      run(32'h402DF854, 32'h40490FDB, 2'd0, 32'h3F5D816A, "e_div_pi", 1'b0);

      run(32'h3F800000, 32'hFFFFFACE, 2'd0, 32'hFFFFFACE, "nan_b", 1'b0);
      run(32'hFFFFFACE, 32'h3F800000, 2'd0, 32'hFFFFFACE, "nan_a", 1'b0);
      run(32'hFFFFFACE, 32'hFFFFBEEF, 2'd0, 32'hFFFFFACE, "nan_both", 1'b0);
      run(32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00001, "snan_quiet", 1'b0);

      run(32'h00000000, 32'h3F800000, 2'd0, 32'h00000000, "zero_div", 1'b0);
      run(32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, "div_zero", 1'b0);
      run(32'h00000000, 32'h00000000, 2'd0, 32'hFFC00000, "zero_zero", 1'b0);
      run(32'h7F800000, 32'h7F800000, 2'd0, 32'hFFC00000, "inf_inf", 1'b0);
      run(32'hBF800000, 32'h00000000, 2'd0, 32'hFF800000, "neg_div_zero", 1'b0);
      run(32'h3F800000, 32'h3F800000, 2'd1, 32'hFFC00000, "op_reserved", 1'b0);

      run(32'h7F7FFFFF, 32'h3E800000, 2'd0, 32'h7F800000, "overflow", 1'b0);
      run(32'h00800000, 32'h40000000, 2'd0, 32'h00000000, "underflow", 1'b0);

      // dispatch pulses while busy must not restart or queue a second result
      run(32'h3F800000, 32'h3F000000, 2'd0, 32'h40000000, "busy_ignore", 1'b1);
      quiet(40, "busy_ignore after");

      // reset mid-divide aborts without a done pulse
      @(negedge clk);
      a = 32'h40490FDB; b = 32'h402DF854; op = 2'd0; dispatch = 1'b1;
      @(negedge clk);
      dispatch = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check(q, 32'd0, "abort q_cleared");
      quiet(40, "abort");
      run(32'h3F800000, 32'h3F800000, 2'd0, 32'h3F800000, "after_abort", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
